// File: rtl/lib_switchblock_pkg.sv
// Shared widths and types for the DEM switching block and its decoder/monitor path.
package lib_switchblock_pkg;

  localparam int unsigned SWITCH_WIDTH  = 16;
  localparam int unsigned REC_WIDTH     = SWITCH_WIDTH + 1;
  localparam int unsigned INTEG_WIDTH   = 20;
  localparam int unsigned INTEG_BOUND   = 4;
  localparam int unsigned ERR_CNT_WIDTH = 16;

  typedef logic signed [REC_WIDTH-1:0]   rec_t;
  typedef logic signed [INTEG_WIDTH-1:0] integ_t;

endpackage

// File: rtl/dem_sat_integrator.sv
// Saturating signed accumulator with a sticky |sum| > BOUND flag and a synchronous clear.
module dem_sat_integrator
  import lib_switchblock_pkg::*;
#(
  parameter int unsigned INC_WIDTH = REC_WIDTH,
  parameter int unsigned SUM_WIDTH = INTEG_WIDTH,
  parameter int unsigned BOUND     = INTEG_BOUND
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic signed [INC_WIDTH-1:0] incr_i,
  output logic signed [SUM_WIDTH-1:0] sum_o,
  output logic                        viol_o
);

  // One bit wider than either operand, so the raw sum can never wrap.
  localparam int unsigned EXT_WIDTH = ((INC_WIDTH > SUM_WIDTH) ? INC_WIDTH : SUM_WIDTH) + 1;

  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX =
    {{(EXT_WIDTH - SUM_WIDTH + 1){1'b0}}, {(SUM_WIDTH - 1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN =
    {{(EXT_WIDTH - SUM_WIDTH + 1){1'b1}}, {(SUM_WIDTH - 1){1'b0}}};
  localparam logic signed [EXT_WIDTH-1:0] BOUND_POS = EXT_WIDTH'(BOUND);
  localparam logic signed [EXT_WIDTH-1:0] BOUND_NEG = -BOUND_POS;

  logic signed [SUM_WIDTH-1:0] r_sum;
  logic                        r_viol;

  logic signed [EXT_WIDTH-1:0] w_sum_ext;
  logic signed [EXT_WIDTH-1:0] w_inc_ext;
  logic signed [EXT_WIDTH-1:0] w_raw;
  logic signed [EXT_WIDTH-1:0] w_sat_ext;
  logic signed [SUM_WIDTH-1:0] w_next;
  logic                        w_over;

  assign w_sum_ext = {{(EXT_WIDTH - SUM_WIDTH){r_sum[SUM_WIDTH-1]}}, r_sum};
  assign w_inc_ext = {{(EXT_WIDTH - INC_WIDTH){incr_i[INC_WIDTH-1]}}, incr_i};

  always_comb begin
    w_raw     = w_sum_ext + w_inc_ext;
    w_sat_ext = w_raw;
    if (w_raw > SAT_MAX) begin
      w_sat_ext = SAT_MAX;
    end else if (w_raw < SAT_MIN) begin
      w_sat_ext = SAT_MIN;
    end
    w_next = w_sat_ext[SUM_WIDTH-1:0];
    // Judged on the saturated value: that is what the accumulator actually holds.
    w_over = (w_sat_ext > BOUND_POS) || (w_sat_ext < BOUND_NEG);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sum  <= '0;
      r_viol <= 1'b0;
    end else if (clear_i) begin
      r_sum  <= '0;
      r_viol <= 1'b0;
    end else if (enable_i) begin
      r_sum  <= w_next;
      r_viol <= r_viol | w_over;
    end
  end

  assign sum_o  = r_sum;
  assign viol_o = r_viol;

endmodule

// File: rtl/dem_switch_decoder.sv
// Inverse of the DEM switching block: rebuilds x = x1+x2 and s = x1-x2, flags disagreement with the
// transmitted s, and tracks the running integral of s behind a two-stage valid/ready pipeline.
module dem_switch_decoder #(
  parameter int unsigned SW_WIDTH      = lib_switchblock_pkg::SWITCH_WIDTH,
  parameter int unsigned REC_WIDTH     = SW_WIDTH + 1,
  parameter int unsigned INTEG_WIDTH   = lib_switchblock_pkg::INTEG_WIDTH,
  parameter int unsigned INTEG_BOUND   = lib_switchblock_pkg::INTEG_BOUND,
  parameter int unsigned ERR_CNT_WIDTH = lib_switchblock_pkg::ERR_CNT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic signed [SW_WIDTH-1:0]    x1_i,
  input  logic signed [SW_WIDTH-1:0]    x2_i,
  input  logic signed [SW_WIDTH-1:0]    s_i,
  input  logic                          clear_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic signed [REC_WIDTH-1:0]   x_rec_o,
  output logic signed [REC_WIDTH-1:0]   s_rec_o,
  output logic                          mismatch_o,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o,
  output logic signed [INTEG_WIDTH-1:0] integ_o,
  output logic                          bound_viol_o
);

  import lib_switchblock_pkg::*;

  logic                          w_stall;
  logic                          w_in_xfer;
  logic                          w_s2_load;
  logic                          w_s1_mismatch;
  logic signed [REC_WIDTH-1:0]   w_x1_ext;
  logic signed [REC_WIDTH-1:0]   w_x2_ext;
  logic signed [REC_WIDTH-1:0]   w_s_ext;
  logic signed [INTEG_WIDTH-1:0] w_integ;
  logic                          w_bound_viol;

  logic                          r_s1_valid;
  logic signed [REC_WIDTH-1:0]   r_s1_sum;
  logic signed [REC_WIDTH-1:0]   r_s1_diff;
  logic signed [REC_WIDTH-1:0]   r_s1_s;

  logic                          r_s2_valid;
  logic signed [REC_WIDTH-1:0]   r_x_rec;
  logic signed [REC_WIDTH-1:0]   r_s_rec;
  logic                          r_mismatch;
  logic [ERR_CNT_WIDTH-1:0]      r_err_cnt;

  // The whole pipeline freezes as one while the output word is held.
  assign w_stall       = r_s2_valid & ~ready_i;
  assign ready_o       = ~w_stall;
  assign w_in_xfer     = valid_i & ~w_stall;
  assign w_s2_load     = r_s1_valid & ~w_stall;
  assign w_s1_mismatch = (r_s1_diff != r_s1_s);

  assign w_x1_ext = {{(REC_WIDTH - SW_WIDTH){x1_i[SW_WIDTH-1]}}, x1_i};
  assign w_x2_ext = {{(REC_WIDTH - SW_WIDTH){x2_i[SW_WIDTH-1]}}, x2_i};
  assign w_s_ext  = {{(REC_WIDTH - SW_WIDTH){s_i[SW_WIDTH-1]}}, s_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_diff  <= '0;
      r_s1_s     <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_in_xfer;
      if (w_in_xfer) begin
        r_s1_sum  <= w_x1_ext + w_x2_ext;
        r_s1_diff <= w_x1_ext - w_x2_ext;
        r_s1_s    <= w_s_ext;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s2_valid <= 1'b0;
      r_x_rec    <= '0;
      r_s_rec    <= '0;
      r_mismatch <= 1'b0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      // A bubble keeps the old data but must not report a mismatch.
      r_mismatch <= r_s1_valid & w_s1_mismatch;
      if (r_s1_valid) begin
        r_x_rec <= r_s1_sum;
        r_s_rec <= r_s1_diff;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_err_cnt <= '0;
    end else if (clear_i) begin
      r_err_cnt <= '0;
    end else if (w_s2_load && w_s1_mismatch && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  dem_sat_integrator #(
    .INC_WIDTH (REC_WIDTH),
    .SUM_WIDTH (INTEG_WIDTH),
    .BOUND     (INTEG_BOUND)
  ) u_integ (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .enable_i (w_s2_load),
    .clear_i  (clear_i),
    .incr_i   (r_s1_diff),
    .sum_o    (w_integ),
    .viol_o   (w_bound_viol)
  );

  assign valid_o      = r_s2_valid;
  assign x_rec_o      = r_x_rec;
  assign s_rec_o      = r_s_rec;
  assign mismatch_o   = r_mismatch;
  assign err_cnt_o    = r_err_cnt;
  assign integ_o      = w_integ;
  assign bound_viol_o = w_bound_viol;

endmodule

// File: tb/tb_dem_switch_decoder.sv
// Bench for dem_switch_decoder: a default instance and a narrow-counter instance share stimulus
// and are checked every cycle against a word-level model of the decoder.
module tb_dem_switch_decoder;

  localparam int unsigned SW = 16;
  localparam int unsigned RW = SW + 1;

  logic clk_i = 1'b0;
  logic reset_i, valid_i, ready_i, clear_i;
  logic signed [SW-1:0] x1_i, x2_i, s_i;

  logic ready_o, valid_o, mismatch_o, bound_viol_o;
  logic signed [RW-1:0] x_rec_o, s_rec_o;
  logic [15:0] err_cnt_o;
  logic signed [19:0] integ_o;

  logic sm_ready_o, sm_valid_o, sm_mismatch_o, sm_bound_viol_o;
  logic signed [RW-1:0] sm_x_rec_o, sm_s_rec_o;
  logic [1:0] sm_err_cnt_o;
  logic signed [7:0] sm_integ_o;

  always #5 clk_i = ~clk_i;

  dem_switch_decoder u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .x1_i(x1_i), .x2_i(x2_i), .s_i(s_i), .clear_i(clear_i),
    .valid_o(valid_o), .ready_i(ready_i), .x_rec_o(x_rec_o), .s_rec_o(s_rec_o),
    .mismatch_o(mismatch_o), .err_cnt_o(err_cnt_o), .integ_o(integ_o),
    .bound_viol_o(bound_viol_o)
  );

  dem_switch_decoder #(.INTEG_WIDTH(8), .ERR_CNT_WIDTH(2)) u_dut_small (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(sm_ready_o),
    .x1_i(x1_i), .x2_i(x2_i), .s_i(s_i), .clear_i(clear_i),
    .valid_o(sm_valid_o), .ready_i(ready_i), .x_rec_o(sm_x_rec_o), .s_rec_o(sm_s_rec_o),
    .mismatch_o(sm_mismatch_o), .err_cnt_o(sm_err_cnt_o), .integ_o(sm_integ_o),
    .bound_viol_o(sm_bound_viol_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit en_cmp  = 1'b1;

  typedef struct {
    longint xr; longint sr; bit mm;
    longint em; longint im; bit vm;
    longint es; longint is; bit vs;
  } exp_t;

  exp_t   q[$];
  exp_t   shown;
  longint run_em, run_im, run_es, run_is;
  bit     run_vm, run_vs;
  longint obs_xr[$], obs_im[$], obs_vm[$], obs_es[$], obs_is[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  function automatic void reset_counters();
    run_em = 0; run_im = 0; run_es = 0; run_is = 0; run_vm = 0; run_vs = 0;
    shown.em = 0; shown.im = 0; shown.vm = 0; shown.es = 0; shown.is = 0; shown.vs = 0;
  endfunction

  // Word-level model: what the outputs must show for each accepted word, in order.
  always @(negedge clk_i) begin
    if (reset_i) begin
      q.delete();
      reset_counters();
    end else begin
      if (en_cmp) begin
        check("ready_o", ready_o, !(valid_o && !ready_i));
        check("sm_ready_o", sm_ready_o, !(valid_o && !ready_i));
        check("sm_valid_o", sm_valid_o, valid_o);
        if (valid_o && q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL valid_no_word: got valid_o=1, expected 0 with nothing in flight");
        end else if (valid_o) begin
          check("x_rec", x_rec_o, q[0].xr);
          check("s_rec", s_rec_o, q[0].sr);
          check("mismatch", mismatch_o, q[0].mm);
          check("err_cnt", err_cnt_o, q[0].em);
          check("integ", integ_o, q[0].im);
          check("bound_viol", bound_viol_o, q[0].vm);
          check("sm_x_rec", sm_x_rec_o, q[0].xr);
          check("sm_s_rec", sm_s_rec_o, q[0].sr);
          check("sm_mismatch", sm_mismatch_o, q[0].mm);
          check("sm_err_cnt", sm_err_cnt_o, q[0].es);
          check("sm_integ", sm_integ_o, q[0].is);
          check("sm_bound_viol", sm_bound_viol_o, q[0].vs);
        end else begin
          check("bubble_mismatch", mismatch_o, 0);
          check("hold_err_cnt", err_cnt_o, shown.em);
          check("hold_integ", integ_o, shown.im);
          check("hold_bound_viol", bound_viol_o, shown.vm);
          check("hold_sm_err_cnt", sm_err_cnt_o, shown.es);
          check("hold_sm_integ", sm_integ_o, shown.is);
        end
      end
      if (valid_o && ready_i) begin
        obs_xr.push_back(longint'(x_rec_o));
        obs_im.push_back(longint'(integ_o));
        obs_vm.push_back(longint'(bound_viol_o));
        obs_es.push_back(longint'(sm_err_cnt_o));
        obs_is.push_back(longint'(sm_integ_o));
        if (q.size() != 0) shown = q.pop_front();
      end
      if (clear_i) reset_counters();
      if (valid_i && ready_o) begin
        exp_t   e;
        longint d;
        d    = longint'(x1_i) - longint'(x2_i);
        e.xr = longint'(x1_i) + longint'(x2_i);
        e.sr = d;
        e.mm = (d != longint'(s_i));
        run_im = sat(run_im + d, 20);
        run_is = sat(run_is + d, 8);
        run_vm = run_vm | (run_im > 4 || run_im < -4);
        run_vs = run_vs | (run_is > 4 || run_is < -4);
        run_em = (run_em + e.mm > 65535) ? 65535 : run_em + e.mm;
        run_es = (run_es + e.mm > 3) ? 3 : run_es + e.mm;
        e.em = run_em; e.im = run_im; e.vm = run_vm;
        e.es = run_es; e.is = run_is; e.vs = run_vs;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic drive_word(input int a, input int b, input int c);
    int n;
    bit acc;
    valid_i = 1'b1; x1_i = 16'(a); x2_i = 16'(b); s_i = 16'(c);
    n = 0; acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i); #1;
      n++;
    end
    valid_i = 1'b0;
    check("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid_i = 1'b0; ready_i = 1'b1;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_timeout", q.size(), 0);
    tick();
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic clear_obs();
    obs_xr.delete(); obs_im.delete(); obs_vm.delete(); obs_es.delete(); obs_is.delete();
  endtask

  initial begin
    longint exp3[4]  = '{2, 4, 6, 8};
    longint exp4i[5] = '{1, 2, 3, 4, 5};
    longint exp4v[5] = '{0, 0, 0, 0, 1};
    longint exp5e[8] = '{1, 2, 3, 3, 3, 3, 3, 3};
    longint exp5i[8] = '{0, 0, 0, 0, 0, 100, 127, 127};
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_i = 1'b0;
    x1_i = '0; x2_i = '0; s_i = '0;
    reset_counters();

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_valid_o", valid_o, 0);
    check("rst_ready_o", ready_o, 1);
    check("rst_x_rec", x_rec_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_integ", integ_o, 0);
    check("rst_bound_viol", bound_viol_o, 0);
    tick();
    reset_i = 1'b0;

    // Basic word and two-cycle latency
    drive_word(30, 20, 10);
    check("t1_not_yet_valid", valid_o, 0);
    tick();
    check("t1_valid_o", valid_o, 1);
    check("t1_x_rec", x_rec_o, 50);
    check("t1_s_rec", s_rec_o, 10);
    check("t1_mismatch", mismatch_o, 0);
    check("t1_err_cnt", err_cnt_o, 0);
    check("t1_integ", integ_o, 10);
    check("t1_bound_viol", bound_viol_o, 1);

    // Mismatch counting
    drain();
    pulse_clear();
    drive_word(-7, 3, -9);
    tick();
    check("t2_x_rec", x_rec_o, -4);
    check("t2_s_rec", s_rec_o, -10);
    check("t2_mismatch", mismatch_o, 1);
    check("t2_err_cnt", err_cnt_o, 1);
    drive_word(-7, 3, -9);
    tick();
    check("t2_err_cnt_2", err_cnt_o, 2);

    // Back-to-back with a three-cycle downstream stall
    drain();
    clear_obs();
    fork
      begin : drv3
        for (int k = 1; k <= 4; k++) drive_word(k, k, 0);
      end
      begin : stall3
        int     n;
        longint hold;
        n = 0;
        while (!valid_o && n < 20) begin
          tick();
          n++;
        end
        check("t3_first_valid", valid_o, 1);
        ready_i = 1'b0;
        hold = longint'(x_rec_o);
        repeat (3) begin
          @(negedge clk_i);
          check("t3_stall_ready_o", ready_o, 0);
          check("t3_stall_x_rec", x_rec_o, hold);
          tick();
        end
        ready_i = 1'b1;
      end
    join
    drain();
    check("t3_count", obs_xr.size(), 4);
    for (int i = 0; i < 4 && i < obs_xr.size(); i++) check("t3_order", obs_xr[i], exp3[i]);

    // Integrator bound
    pulse_clear();
    clear_obs();
    for (int i = 0; i < 5; i++) drive_word(1, 0, 1);
    drain();
    check("t4_count", obs_im.size(), 5);
    for (int i = 0; i < 5 && i < obs_im.size(); i++) begin
      check("t4_integ", obs_im[i], exp4i[i]);
      check("t4_bound_viol", obs_vm[i], exp4v[i]);
    end
    pulse_clear();
    check("t4_clear_integ", integ_o, 0);
    check("t4_clear_bound_viol", bound_viol_o, 0);

    // Saturation on the narrow instance
    clear_obs();
    for (int i = 0; i < 5; i++) drive_word(0, 0, 1);
    for (int i = 0; i < 3; i++) drive_word(100, 0, 100);
    drain();
    check("t5_count", obs_es.size(), 8);
    for (int i = 0; i < 8 && i < obs_es.size(); i++) begin
      check("t5_sm_err_cnt", obs_es[i], exp5e[i]);
      check("t5_sm_integ", obs_is[i], exp5i[i]);
    end

    // Randomized traffic with random backpressure
    pulse_clear();
    for (int c = 0; c < 1500; c++) begin
      int a, b;
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) - 20 : int'($urandom);
      b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) - 20 : int'($urandom);
      x1_i = 16'(a);
      x2_i = 16'(b);
      s_i = ($urandom_range(0, 3) != 0) ? 16'(x1_i - x2_i) : 16'($urandom);
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Asynchronous reset with two words in flight
    drive_word(5, 1, 4);
    drive_word(6, 1, 5);
    #2 reset_i = 1'b1;
    #1;
    check("t6_rst_valid_o", valid_o, 0);
    check("t6_rst_x_rec", x_rec_o, 0);
    check("t6_rst_s_rec", s_rec_o, 0);
    check("t6_rst_mismatch", mismatch_o, 0);
    check("t6_rst_err_cnt", err_cnt_o, 0);
    check("t6_rst_integ", integ_o, 0);
    check("t6_rst_bound_viol", bound_viol_o, 0);
    check("t6_rst_sm_valid", sm_valid_o, 0);
    tick();
    reset_i = 1'b0;
    repeat (3) begin
      tick();
      check("t6_no_valid_after_reset", valid_o, 0);
    end

    // Clear landing on the same edge as a mismatching stage-2 load
    en_cmp = 1'b0;
    drive_word(3, 0, 5);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t6_clr_valid_o", valid_o, 1);
    check("t6_clr_x_rec", x_rec_o, 3);
    check("t6_clr_mismatch", mismatch_o, 1);
    check("t6_clr_err_cnt", err_cnt_o, 0);
    check("t6_clr_integ", integ_o, 0);
    check("t6_clr_bound_viol", bound_viol_o, 0);
    check("t6_clr_sm_err_cnt", sm_err_cnt_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
